// File: rtl/i2c_reg_bank.sv
// Register bank behind i2c_simple_slave: pointer byte then data, with auto-increment
// on both writes and reads, plus a fabric write port that wins collisions.
module i2c_reg_bank #(
  parameter int                  NUM_REGS = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  localparam int                 PW       = $clog2(NUM_REGS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            i2c_addr_rw,
  input  logic                  i2c_addr_rw_valid_stb,
  input  logic [7:0]            i2c_data_rx,
  input  logic                  i2c_data_rx_valid_stb,
  output logic [7:0]            i2c_data_tx,
  input  logic                  i2c_data_tx_loaded_stb,
  input  logic                  i2c_data_tx_done_stb,
  input  logic                  i2c_error_stb,
  output logic                  stall,
  output logic [8*NUM_REGS-1:0] regs_flat,
  input  logic                  hw_wr_en,
  input  logic [PW-1:0]         hw_wr_addr,
  input  logic [7:0]            hw_wr_data,
  output logic                  reg_wr_stb,
  output logic [PW-1:0]         reg_wr_addr
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_PTR,
    S_WRITE,
    S_READ
  } state_t;

  state_t        state, state_next;
  logic [PW-1:0] ptr, ptr_next;
  logic [7:0]    regs [NUM_REGS];
  logic          i2c_wr;
  logic          read_entry;
  logic          tx_valid;
  logic          stall_next;
  logic          unused_inputs;

  // Upper address bits and the tx-done pulse carry nothing this bank acts on.
  assign unused_inputs = ^{i2c_addr_rw, i2c_data_rx, i2c_data_tx_done_stb};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      ptr   <= '0;
    end else begin
      state <= state_next;
      ptr   <= ptr_next;
    end
  end

  // An address match restarts the transaction from any state, so repeated
  // start needs no special case; an error parks the FSM but keeps ptr.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    i2c_wr     = 1'b0;
    read_entry = 1'b0;
    if (i2c_addr_rw_valid_stb) begin
      if (i2c_addr_rw[0]) begin
        state_next = S_READ;
        read_entry = 1'b1;
      end else begin
        state_next = S_PTR;
      end
    end else if (i2c_error_stb) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_PTR: begin
          if (i2c_data_rx_valid_stb) begin
            ptr_next   = i2c_data_rx[PW-1:0];
            state_next = S_WRITE;
          end
        end
        S_WRITE: begin
          if (i2c_data_rx_valid_stb) begin
            i2c_wr   = !RO_MASK[ptr];
            ptr_next = ptr + PW'(1);
          end
        end
        S_READ: begin
          if (i2c_data_tx_loaded_stb) begin
            ptr_next = ptr + PW'(1);
          end
        end
        default: begin
        end
      endcase
    end

    // The registered tx byte is stale for one cycle after anything it
    // depends on moves; stalling on that cycle keeps the slave from loading it.
    tx_valid   = !((ptr_next != ptr) || i2c_wr || (hw_wr_en && (hw_wr_addr == ptr)));
    stall_next = (state_next == S_READ) && (read_entry || !tx_valid);
  end

  // Fabric write is applied last so it overrides a same-index I2C write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else begin
      if (i2c_wr) begin
        regs[ptr] <= i2c_data_rx;
      end
      if (hw_wr_en) begin
        regs[hw_wr_addr] <= hw_wr_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      i2c_data_tx <= '0;
      stall       <= 1'b0;
      reg_wr_stb  <= 1'b0;
      reg_wr_addr <= '0;
    end else begin
      i2c_data_tx <= regs[ptr];
      stall       <= stall_next;
      reg_wr_stb  <= i2c_wr;
      if (i2c_wr) begin
        reg_wr_addr <= ptr;
      end
    end
  end

  always_comb begin
    regs_flat = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      regs_flat[8*i +: 8] = regs[i];
    end
  end

endmodule
